// File: rtl/alu_operand_stage_pkg.sv
// Shared operand-select encodings for the ALU operand stage and its forwarding mux.
package alu_operand_stage_pkg;

    typedef enum logic [2:0] {
        SRCB_RS2     = 3'b000,
        SRCB_SEXT    = 3'b001,
        SRCB_ZEXT    = 3'b010,
        SRCB_SEXT_L1 = 3'b011,
        SRCB_JOFF    = 3'b100,
        SRCB_TWO     = 3'b101
    } src_b_e;

    localparam logic SRCA_RS1 = 1'b0;
    localparam logic SRCA_PC  = 1'b1;

endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// Combinational bypass mux for one source register: EX/MEM beats MEM/WB beats the register file.
module fwd_select #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              mem_wr_en,
    input  logic [REG_AW-1:0] mem_wr_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_wr_addr,
    input  logic [DATA_W-1:0] wb_wr_data,
    output logic [DATA_W-1:0] fwd_data
);

    logic is_zero_reg_s;

    assign is_zero_reg_s = (ZERO_REG != 0) && (addr == {REG_AW{1'b0}});

    // Priority select of the freshest producer for this address
    always_comb begin
        fwd_data = rf_data;
        if (is_zero_reg_s) begin
            fwd_data = {DATA_W{1'b0}};
        end else if (mem_wr_en && (mem_wr_addr == addr)) begin
            fwd_data = mem_wr_data;
        end else if (wb_wr_en && (wb_wr_addr == addr)) begin
            fwd_data = wb_wr_data;
        end else begin
            fwd_data = rf_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand register: selects and forwards ALU operands, detects load-use hazards,
// and presents them through a valid/ready handshake with flush.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int IMM_W    = 8,
    parameter int JIMM_W   = 12,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] pc,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [IMM_W-1:0]  imm,
    input  logic [JIMM_W-1:0] jimm,
    input  logic              src_a_sel,
    input  logic [2:0]        src_b_sel,
    input  logic              mem_wr_en,
    input  logic [REG_AW-1:0] mem_wr_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_wr_addr,
    input  logic [DATA_W-1:0] wb_wr_data,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] store_data,
    output logic              stall
);

    logic [DATA_W-1:0] rs1_fwd_s;
    logic [DATA_W-1:0] rs2_fwd_s;
    logic [DATA_W-1:0] sext_imm_s;
    logic [DATA_W-1:0] zext_imm_s;
    logic [DATA_W-1:0] sext_jimm_s;
    logic [DATA_W-1:0] next_a_s;
    logic [DATA_W-1:0] next_b_s;
    logic              rs1_used_s;
    logic              rs2_used_s;
    logic              adv_s;
    logic              load_s;
    logic              out_valid_r;
    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [DATA_W-1:0] store_data_r;

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_rs1 (
        .addr        (rs1_addr),
        .rf_data     (rs1_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .wb_wr_en    (wb_wr_en),
        .wb_wr_addr  (wb_wr_addr),
        .wb_wr_data  (wb_wr_data),
        .fwd_data    (rs1_fwd_s)
    );

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_rs2 (
        .addr        (rs2_addr),
        .rf_data     (rs2_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .wb_wr_en    (wb_wr_en),
        .wb_wr_addr  (wb_wr_addr),
        .wb_wr_data  (wb_wr_data),
        .fwd_data    (rs2_fwd_s)
    );

    assign sext_imm_s  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign zext_imm_s  = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign sext_jimm_s = {{(DATA_W-JIMM_W){jimm[JIMM_W-1]}}, jimm};

    // rs2 always feeds store_data, so it counts as used for any live address
    assign rs1_used_s = (src_a_sel == SRCA_RS1) &&
                        !((ZERO_REG != 0) && (rs1_addr == {REG_AW{1'b0}}));
    assign rs2_used_s = !((ZERO_REG != 0) && (rs2_addr == {REG_AW{1'b0}}));

    assign stall    = in_valid && ld_valid &&
                      ((rs1_used_s && (rs1_addr == ld_addr)) ||
                       (rs2_used_s && (rs2_addr == ld_addr)));
    assign adv_s    = !out_valid_r || out_ready;
    assign in_ready = adv_s && !stall;
    assign load_s   = adv_s && in_valid && !stall && !flush;

    // Operand A source selection
    always_comb begin
        next_a_s = rs1_fwd_s;
        if (src_a_sel == SRCA_PC) begin
            next_a_s = pc;
        end else begin
            next_a_s = rs1_fwd_s;
        end
    end

    // Operand B source selection; shifted forms drop the MSB
    always_comb begin
        next_b_s = {DATA_W{1'b0}};
        case (src_b_sel)
            SRCB_RS2:     next_b_s = rs2_fwd_s;
            SRCB_SEXT:    next_b_s = sext_imm_s;
            SRCB_ZEXT:    next_b_s = zext_imm_s;
            SRCB_SEXT_L1: next_b_s = {sext_imm_s[DATA_W-2:0], 1'b0};
            SRCB_JOFF:    next_b_s = {sext_jimm_s[DATA_W-2:0], 1'b0};
            SRCB_TWO:     next_b_s = {{(DATA_W-2){1'b0}}, 2'b10};
            default:      next_b_s = {DATA_W{1'b0}};
        endcase
    end

    // Output register: flush kills the held slot even under backpressure
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            alu_a_r      <= {DATA_W{1'b0}};
            alu_b_r      <= {DATA_W{1'b0}};
            store_data_r <= {DATA_W{1'b0}};
        end else begin
            if (flush) begin
                out_valid_r <= 1'b0;
            end else if (adv_s) begin
                out_valid_r <= load_s;
            end
            if (load_s) begin
                alu_a_r      <= next_a_s;
                alu_b_r      <= next_b_s;
                store_data_r <= rs2_fwd_s;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign store_data = store_data_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pc;
    logic [3:0]  rs1_addr, rs2_addr;
    logic [15:0] rs1_data, rs2_data;
    logic [7:0]  imm;
    logic [11:0] jimm;
    logic        src_a_sel;
    logic [2:0]  src_b_sel;
    logic        mem_wr_en, wb_wr_en;
    logic [3:0]  mem_wr_addr, wb_wr_addr;
    logic [15:0] mem_wr_data, wb_wr_data;
    logic        ld_valid;
    logic [3:0]  ld_addr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] alu_a, alu_b, store_data;
    logic        stall;

    int vectors;
    int miscompares;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .pc(pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .jimm(jimm), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data),
        .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 1'b0; pc = 16'h0000; rs1_addr = 4'd1; rs2_addr = 4'd2;
        rs1_data = 16'h0000; rs2_data = 16'h0000; imm = 8'h00; jimm = 12'h000;
        src_a_sel = 1'b0; src_b_sel = 3'b000; mem_wr_en = 1'b0; mem_wr_addr = 4'd0;
        mem_wr_data = 16'h0000; wb_wr_en = 1'b0; wb_wr_addr = 4'd0; wb_wr_data = 16'h0000;
        ld_valid = 1'b0; ld_addr = 4'd0; flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0; in_valid = 1'b1; rs1_data = 16'hA5A5; rs2_data = 16'h5A5A;
        tick(); tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        vectors++; if (alu_a !== 16'h0000 || alu_b !== 16'h0000) begin miscompares++; $display("FAIL reset_data: got a=%h b=%h expected 0000/0000", alu_a, alu_b); end
        rst_n = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b1 || alu_a !== 16'hA5A5) begin miscompares++; $display("FAIL reset_first_accept: got v=%b a=%h expected 1/a5a5", out_valid, alu_a); end
    endtask

    task automatic test_mux_sweep();
        logic [15:0] exp_b [8];
        exp_b = '{16'hBBBB, 16'hFF88, 16'h0088, 16'hFF10, 16'hF332, 16'h0002, 16'h0000, 16'h0000};
        set_idle();
        in_valid = 1'b1; pc = 16'hFFFF; rs1_data = 16'hEEEE; rs2_data = 16'hBBBB;
        imm = 8'h88; jimm = 12'h999;
        for (int i = 0; i < 8; i++) begin
            src_b_sel = 3'(i);
            tick();
            vectors++; if (alu_b !== exp_b[i] || alu_a !== 16'hEEEE || out_valid !== 1'b1) begin
                miscompares++; $display("FAIL mux_b%0d: got v=%b a=%h b=%h expected 1/eeee/%h", i, out_valid, alu_a, alu_b, exp_b[i]);
            end
        end
        src_a_sel = 1'b1; src_b_sel = 3'b000;
        tick();
        vectors++; if (alu_a !== 16'hFFFF || store_data !== 16'hBBBB) begin miscompares++; $display("FAIL mux_a_pc: got a=%h sd=%h expected ffff/bbbb", alu_a, store_data); end
    endtask

    task automatic test_forwarding();
        set_idle();
        in_valid = 1'b1; rs1_addr = 4'd3; rs1_data = 16'hEEEE;
        mem_wr_en = 1'b1; mem_wr_addr = 4'd3; mem_wr_data = 16'h1234;
        wb_wr_en = 1'b1; wb_wr_addr = 4'd3; wb_wr_data = 16'h5678;
        tick();
        vectors++; if (alu_a !== 16'h1234) begin miscompares++; $display("FAIL fwd_mem_prio: got %h expected 1234", alu_a); end
        mem_wr_en = 1'b0;
        tick();
        vectors++; if (alu_a !== 16'h5678) begin miscompares++; $display("FAIL fwd_wb: got %h expected 5678", alu_a); end
        rs1_addr = 4'd0; mem_wr_en = 1'b1; mem_wr_addr = 4'd0; wb_wr_addr = 4'd0;
        tick();
        vectors++; if (alu_a !== 16'h0000) begin miscompares++; $display("FAIL fwd_zero_reg: got %h expected 0000", alu_a); end
        mem_wr_en = 1'b0; rs2_addr = 4'd4; rs2_data = 16'h1111; wb_wr_addr = 4'd4;
        wb_wr_data = 16'h9ABC; src_b_sel = 3'b001; imm = 8'h7F;
        tick();
        vectors++; if (store_data !== 16'h9ABC || alu_b !== 16'h007F) begin miscompares++; $display("FAIL fwd_store: got sd=%h b=%h expected 9abc/007f", store_data, alu_b); end
    endtask

    task automatic test_load_use();
        set_idle();
        in_valid = 1'b1; rs1_addr = 4'd1; rs1_data = 16'h0101; rs2_addr = 4'd5; rs2_data = 16'h0505;
        ld_valid = 1'b1; ld_addr = 4'd5;
        #1;
        vectors++; if (stall !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL ldu_stall: got stall=%b rdy=%b expected 1/0", stall, in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ldu_bubble: got %b expected 0", out_valid); end
        ld_valid = 1'b0;
        #1;
        vectors++; if (stall !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL ldu_release: got stall=%b rdy=%b expected 0/1", stall, in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b1 || alu_b !== 16'h0505) begin miscompares++; $display("FAIL ldu_accept: got v=%b b=%h expected 1/0505", out_valid, alu_b); end
        ld_valid = 1'b1; ld_addr = 4'd0; rs1_addr = 4'd0; rs2_addr = 4'd0;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL ldu_r0: got %b expected 0", stall); end
        ld_addr = 4'd7; rs2_addr = 4'd7; src_b_sel = 3'b101;
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL ldu_store_rs2: got %b expected 1", stall); end
    endtask

    task automatic test_backpressure();
        set_idle();
        in_valid = 1'b1; rs1_data = 16'h1111; rs2_data = 16'h2222;
        tick();
        vectors++; if (out_valid !== 1'b1 || alu_a !== 16'h1111) begin miscompares++; $display("FAIL bp_first: got v=%b a=%h expected 1/1111", out_valid, alu_a); end
        out_ready = 1'b0; rs1_data = 16'h3333; rs2_data = 16'h4444;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready%0d: got %b expected 0", i, in_ready); end
            tick();
            vectors++; if (out_valid !== 1'b1 || alu_a !== 16'h1111 || alu_b !== 16'h2222) begin
                miscompares++; $display("FAIL bp_hold%0d: got v=%b a=%h b=%h expected 1/1111/2222", i, out_valid, alu_a, alu_b);
            end
        end
        out_ready = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b1 || alu_a !== 16'h3333 || alu_b !== 16'h4444) begin
            miscompares++; $display("FAIL bp_second: got v=%b a=%h b=%h expected 1/3333/4444", out_valid, alu_a, alu_b);
        end
    endtask

    task automatic test_flush();
        set_idle();
        in_valid = 1'b1; rs1_data = 16'h5555;
        tick();
        out_ready = 1'b0; flush = 1'b1; rs1_data = 16'h7777;
        tick();
        vectors++; if (out_valid !== 1'b0 || alu_a !== 16'h5555) begin miscompares++; $display("FAIL flush_kill: got v=%b a=%h expected 0/5555", out_valid, alu_a); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0 || alu_a === 16'h7777) begin miscompares++; $display("FAIL flush_drop: got v=%b a=%h expected 0/not 7777", out_valid, alu_a); end
        in_valid = 1'b1; rs1_data = 16'h6666; rs2_data = 16'h6060;
        tick();
        rst_n = 1'b0; flush = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0 || alu_a !== 16'h0000 || alu_b !== 16'h0000 || store_data !== 16'h0000) begin
            miscompares++; $display("FAIL flush_reset: got v=%b a=%h b=%h sd=%h expected 0/0/0/0", out_valid, alu_a, alu_b, store_data);
        end
        rst_n = 1'b1; flush = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_mux_sweep();
        test_forwarding();
        test_load_use();
        test_backpressure();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered successor to the combinational pre-ALU operand mux. Selects ALU operands A and B, and the store-data word, from the register file, PC and internally extended immediates.
- Adds operand forwarding from the EX/MEM and MEM/WB pipeline registers, load-use stall detection, a valid/ready handshake and flush.
- Sits between decode/register-read and the ALU. Its output register is the ID/EX operand register.

Parameters:
- DATA_W, 16, datapath width.
- REG_AW, 4, register address width.
- IMM_W, 8, raw short-immediate width.
- JIMM_W, 12, raw jump-offset width.
- ZERO_REG, 1, if 1, register 0 reads as zero and is never forwarded or stalled on.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- pc  in  DATA_W  PC of the instruction.
- rs1_addr, rs2_addr  in  REG_AW  source register addresses.
- rs1_data, rs2_data  in  DATA_W  register-file read data.
- imm  in  IMM_W  short immediate.
- jimm  in  JIMM_W  jump offset.
- src_a_sel  in  1  0 = rs1, 1 = PC.
- src_b_sel  in  3  000 rs2; 001 sext(imm); 010 zext(imm); 011 sext(imm)<<1; 100 sext(jimm)<<1; 101 constant 2; 110/111 zero.
- mem_wr_en, mem_wr_addr, mem_wr_data  in  1/REG_AW/DATA_W  EX/MEM writeback bypass.
- wb_wr_en, wb_wr_addr, wb_wr_data  in  1/REG_AW/DATA_W  MEM/WB writeback bypass.
- ld_valid, ld_addr  in  1/REG_AW  the instruction now in EX is a load writing ld_addr.
- flush  in  1  kill the held and incoming instruction.
- out_valid  out  1  operands valid.
- out_ready  in  1  ALU stage accepts.
- alu_a, alu_b, store_data  out  DATA_W  registered operands; store_data is forwarded rs2.
- stall  out  1  load-use hazard this cycle.

Behaviour:
- Reset: on a clk edge with rst_n=0, out_valid=0 and alu_a=alu_b=store_data=0. Reset has priority over flush and all other inputs.
- Forwarding, applied separately to rs1 and rs2:
  - If ZERO_REG and addr==0, the value is 0.
  - Else if mem_wr_en and mem_wr_addr==addr, the value is mem_wr_data.
  - Else if wb_wr_en and wb_wr_addr==addr, the value is wb_wr_data.
  - Else the register-file data is used.
  - EX/MEM has priority over MEM/WB.
- Operand use: rs1 is "used" when src_a_sel=0. rs2 is "used" when src_b_sel=000. store_data always takes forwarded rs2, and rs2 is also "used" for hazard purposes whenever rs2_addr is nonzero or ZERO_REG=0. An address of 0 with ZERO_REG=1 never counts as used.
- Hazard: stall = in_valid & ld_valid & (an operand that is used has an address equal to ld_addr).
- Ready: in_ready = (!out_valid | out_ready) & !stall.
- Advance: the output register updates when adv = !out_valid | out_ready.
  - If adv and in_valid & !stall & !flush: load the operands and set out_valid=1.
  - If adv otherwise: out_valid=0 (bubble inserted); data registers hold.
  - If !adv: all outputs hold, and stall does not change them.
- Flush: on the edge, out_valid becomes 0 regardless of out_ready. The incoming instruction is dropped, and in_ready is still reported to decode so it can discard. Flush together with stall gives out_valid=0.
- Latency: exactly 1 cycle from acceptance to out_valid.
- Throughput: 1 instruction per cycle when there is no stall or backpressure.
- Arithmetic:
  - sext/zext extend to DATA_W.
  - A shift <<1 discards the MSB; no overflow flag.
  - Constant 2 is 2 modulo 2^DATA_W.
- alu_a/alu_b change only on a load event; they are stable while out_valid & !out_ready.

Decomposition:
- Shared package: src_b_sel encodings (SRCB_RS2, SRCB_SEXT, SRCB_ZEXT, SRCB_SEXT_L1, SRCB_JOFF, SRCB_TWO) and SRCA_RS1/SRCA_PC.
- One sub-module, fwd_select, instantiated twice (rs1, rs2). It is combinational: addr, rf data and both bypass buses in, forwarded value out.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0 and alu_a=alu_b=0; the first accept occurs the cycle after rst_n=1.
- Mux sweep: pc=FFFF, rs1_data=EEEE, rs2_data=BBBB, imm=8'h88, jimm=12'h999, no bypass. For src_b 000..111 expect BBBB, FF88, 0088, FF10, F332, 0002, 0000, 0000. src_a=1 gives FFFF.
- Forwarding: rs1_addr=3, mem_wr(3)=1234 and wb_wr(3)=5678 -> alu_a=1234. Drop mem_wr -> 5678. rs1_addr=0 with both bypasses on 0 -> 0000.
- Load-use: ld_valid=1, ld_addr=5, rs2_addr=5, src_b=000 -> stall=1, in_ready=0, out_valid=0 next cycle. ld_valid=0 -> accepted, out_valid=1.
- Backpressure: out_ready=0 for 3 cycles with a new in_valid -> alu_a/alu_b hold the first instruction's values and in_ready=0. out_ready=1 -> the second instruction loads on the next edge.
- Flush: flush=1 with out_valid=1, out_ready=0 and in_valid=1 -> out_valid=0 next cycle and the incoming instruction never appears. Flush with rst_n=0 -> reset values.
